// File: rtl/ysyx_23060184_lsu.sv
// ysyx_23060184_lsu: load/store unit between execute and writeback.
// Takes one decoded memory op at a time, issues a single word-aligned
// request on the data-memory port, waits for the response, and returns
// sign/zero-extended load data (or zero for stores) with an error flag.

`ifndef ROPCODE_LENGTH
`define ROPCODE_LENGTH 3
`endif
`ifndef WMASK_LENGTH
`define WMASK_LENGTH 2
`endif

module ysyx_23060184_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  input  logic                       MemRead,
  input  logic                       MemWrite,
  input  logic [`ROPCODE_LENGTH-1:0] Ropcode,
  input  logic [`WMASK_LENGTH-1:0]   Wmask,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_wstrb,
  input  logic                       mem_resp_valid,
  input  logic [31:0]                mem_rdata,
  input  logic                       mem_resp_err,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                rdata,
  output logic                       err
);

  localparam int RW = `ROPCODE_LENGTH;
  localparam int MW = `WMASK_LENGTH;

  // Load kinds (Ropcode) and store kinds (Wmask) as decoded by the control unit
  localparam logic [RW-1:0] READ_WORD  = RW'(1);
  localparam logic [RW-1:0] READ_HALF  = RW'(2);
  localparam logic [RW-1:0] READ_BYTE  = RW'(3);
  localparam logic [RW-1:0] READ_HALFU = RW'(4);
  localparam logic [RW-1:0] READ_BYTEU = RW'(5);

  localparam logic [MW-1:0] WRITE_WORD = MW'(1);
  localparam logic [MW-1:0] WRITE_HALF = MW'(2);
  localparam logic [MW-1:0] WRITE_BYTE = MW'(3);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  // A zero limit disables the watchdog entirely
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  // Access size of a load; unknown kinds fall back to a full word
  function automatic logic [1:0] load_size(input logic [RW-1:0] ro);
    case (ro)
      READ_HALF, READ_HALFU: return SZ_HALF;
      READ_BYTE, READ_BYTEU: return SZ_BYTE;
      default:               return SZ_WORD;
    endcase
  endfunction

  // Access size of a store; zero and unknown kinds mean a full word
  function automatic logic [1:0] store_size(input logic [MW-1:0] wm);
    case (wm)
      WRITE_HALF: return SZ_HALF;
      WRITE_BYTE: return SZ_BYTE;
      WRITE_WORD: return SZ_WORD;
      default:    return SZ_WORD;
    endcase
  endfunction

  // Word accesses need offset 0, halfword accesses need an even offset
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_WORD: return (off != 2'b00);
      SZ_HALF: return off[0];
      default: return 1'b0;
    endcase
  endfunction

  // Byte-lane strobes for a store of the given size at the given offset
  function automatic logic [3:0] byte_strb(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_WORD: return 4'b1111;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b0001 << off;
    endcase
  endfunction

  // Right-align the addressed lanes of the read word, then extend per load kind
  function automatic logic [31:0] load_extend(input logic [RW-1:0] ro,
                                              input logic [31:0]   word,
                                              input logic [1:0]    off);
    logic [31:0] w;
    w = word >> {off, 3'b000};
    case (ro)
      READ_BYTE:  return {{24{w[7]}}, w[7:0]};
      READ_BYTEU: return {24'd0, w[7:0]};
      READ_HALF:  return {{16{w[15]}}, w[15:0]};
      READ_HALFU: return {16'd0, w[15:0]};
      default:    return w;
    endcase
  endfunction

  logic [1:0]    state;
  logic [31:0]   tcnt;
  logic [1:0]    off_q;
  logic [RW-1:0] ropc_q;
  logic          store_q;

  logic          is_store;
  logic          is_load;
  logic [RW-1:0] ropc_eff;
  logic [1:0]    size_in;
  logic          mis_in;
  logic          to_hit;

  assign in_ready = rstn && (state == IDLE);
  assign to_hit   = TO_EN && (tcnt == TO_LAST);

  // Classify the incoming op: store wins over load, neither means no-op
  always_comb begin
    is_store = MemWrite;
    is_load  = !MemWrite && MemRead;
    ropc_eff = (Ropcode == '0) ? READ_WORD : Ropcode;
    size_in  = is_store ? store_size(Wmask) : load_size(ropc_eff);
    mis_in   = (is_store || is_load) && misaligned(size_in, addr[1:0]);
  end

  // Remember what the response handler needs to shape load data
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      off_q   <= addr[1:0];
      ropc_q  <= ropc_eff;
      store_q <= is_store;
    end
  end

  // Transaction FSM: accept, request, await response, hold result
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      tcnt          <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      out_valid     <= 1'b0;
      rdata         <= '0;
      err           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            tcnt <= '0;
            if (!is_store && !is_load) begin
              state     <= DONE;
              out_valid <= 1'b1;
              rdata     <= '0;
              err       <= 1'b0;
            end else if (mis_in) begin
              state     <= DONE;
              out_valid <= 1'b1;
              rdata     <= '0;
              err       <= 1'b1;
            end else begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_we        <= is_store;
              mem_addr      <= {addr[31:2], 2'b00};
              mem_wstrb     <= is_store ? byte_strb(size_in, addr[1:0]) : 4'b0000;
              mem_wdata     <= wdata << {addr[1:0], 3'b000};
            end
          end
        end
        REQ: begin
          tcnt <= tcnt + 32'd1;
          if (to_hit) begin
            mem_req_valid <= 1'b0;
            state         <= DONE;
            out_valid     <= 1'b1;
            rdata         <= '0;
            err           <= 1'b1;
          end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= RESP;
          end
        end
        RESP: begin
          tcnt <= tcnt + 32'd1;
          if (mem_resp_valid) begin
            state     <= DONE;
            out_valid <= 1'b1;
            rdata     <= store_q ? 32'd0 : load_extend(ropc_q, mem_rdata, off_q);
            err       <= mem_resp_err;
          end else if (to_hit) begin
            state     <= DONE;
            out_valid <= 1'b1;
            rdata     <= '0;
            err       <= 1'b1;
          end
        end
        default: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Directed bench for ysyx_23060184_lsu: two instances share stimulus,
// one with the default watchdog and one with a 4-cycle watchdog.

module tb_ysyx_23060184_lsu;

  localparam logic [2:0] RD_WORD  = 3'd1;
  localparam logic [2:0] RD_HALF  = 3'd2;
  localparam logic [2:0] RD_BYTE  = 3'd3;
  localparam logic [2:0] RD_HALFU = 3'd4;
  localparam logic [2:0] RD_BYTEU = 3'd5;
  localparam logic [1:0] WR_WORD  = 2'd1;
  localparam logic [1:0] WR_HALF  = 2'd2;
  localparam logic [1:0] WR_BYTE  = 2'd3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Ropcode;
  logic [1:0]  Wmask;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        mem_resp_err;
  logic        out_ready;

  logic        a_in_ready, a_req_valid, a_we, a_out_valid, a_err;
  logic [31:0] a_maddr, a_mwdata, a_rdata;
  logic [3:0]  a_wstrb;
  logic        b_in_ready, b_req_valid, b_we, b_out_valid, b_err;
  logic [31:0] b_maddr, b_mwdata, b_rdata;
  logic [3:0]  b_wstrb;

  logic        use_b = 1'b0;
  logic        s_in_ready, s_req_valid, s_we, s_out_valid, s_err;
  logic [31:0] s_maddr, s_mwdata, s_rdata;
  logic [3:0]  s_wstrb;

  int n_checks = 0;
  int n_fail   = 0;

  assign s_in_ready  = use_b ? b_in_ready  : a_in_ready;
  assign s_req_valid = use_b ? b_req_valid : a_req_valid;
  assign s_we        = use_b ? b_we        : a_we;
  assign s_out_valid = use_b ? b_out_valid : a_out_valid;
  assign s_err       = use_b ? b_err       : a_err;
  assign s_maddr     = use_b ? b_maddr     : a_maddr;
  assign s_mwdata    = use_b ? b_mwdata    : a_mwdata;
  assign s_rdata     = use_b ? b_rdata     : a_rdata;
  assign s_wstrb     = use_b ? b_wstrb     : a_wstrb;

  always #5 clk = ~clk;

  ysyx_23060184_lsu u_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(a_in_ready),
    .addr(addr), .wdata(wdata), .MemRead(MemRead), .MemWrite(MemWrite),
    .Ropcode(Ropcode), .Wmask(Wmask),
    .mem_req_valid(a_req_valid), .mem_req_ready(mem_req_ready), .mem_we(a_we),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_wstrb(a_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .out_valid(a_out_valid), .out_ready(out_ready), .rdata(a_rdata), .err(a_err)
  );

  ysyx_23060184_lsu #(.TIMEOUT_CYCLES(4)) u_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(b_in_ready),
    .addr(addr), .wdata(wdata), .MemRead(MemRead), .MemWrite(MemWrite),
    .Ropcode(Ropcode), .Wmask(Wmask),
    .mem_req_valid(b_req_valid), .mem_req_ready(mem_req_ready), .mem_we(b_we),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_wstrb(b_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .out_valid(b_out_valid), .out_ready(out_ready), .rdata(b_rdata), .err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One op through the selected instance with a scripted memory and writeback
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic rd, input logic wr, input logic [2:0] ro,
                        input logic [1:0] wm, input logic [31:0] mrd, input logic merr,
                        input int rdy_delay, input int out_hold,
                        input logic exp_req, input logic [31:0] exp_maddr,
                        input logic exp_we, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat);
    int k;
    int ph;
    int held;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(s_in_ready), 32'd1);
    addr = a; wdata = wd; MemRead = rd; MemWrite = wr; Ropcode = ro; Wmask = wm;
    in_valid = 1'b1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    k = 1; ph = 0; held = 0;
    while (!s_out_valid && k < 60) begin
      if (!exp_req) check({tag, ".no_req"}, 32'(s_req_valid), 32'd0);
      case (ph)
        0: if (s_req_valid) begin
             check({tag, ".mem_addr"}, s_maddr, exp_maddr);
             check({tag, ".mem_we"}, 32'(s_we), 32'(exp_we));
             check({tag, ".mem_wstrb"}, 32'(s_wstrb), 32'(exp_strb));
             check({tag, ".mem_wdata"}, s_mwdata, exp_wdata);
             if (held >= rdy_delay) begin
               mem_req_ready = 1'b1;
               ph = 1;
             end
             held++;
           end
        1: begin
             mem_req_ready = 1'b0;
             mem_resp_valid = 1'b1; mem_rdata = mrd; mem_resp_err = merr;
             ph = 2;
           end
        default: mem_resp_valid = 1'b0;
      endcase
      @(negedge clk);
      k++;
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    check({tag, ".out_valid"}, 32'(s_out_valid), 32'd1);
    check({tag, ".latency"}, 32'(k), 32'(exp_lat));
    if (!exp_req) check({tag, ".no_req_done"}, 32'(s_req_valid), 32'd0);
    check({tag, ".rdata"}, s_rdata, exp_rdata);
    check({tag, ".err"}, 32'(s_err), 32'(exp_err));
    for (int i = 0; i < out_hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(s_out_valid), 32'd1);
      check({tag, ".hold_rdata"}, s_rdata, exp_rdata);
      check({tag, ".hold_err"}, 32'(s_err), 32'(exp_err));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".out_drop"}, 32'(s_out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rstn = 1'b0; in_valid = 1'b0; addr = '0; wdata = '0; MemRead = 1'b0; MemWrite = 1'b0;
    Ropcode = '0; Wmask = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    mem_rdata = '0; mem_resp_err = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.in_ready_low", 32'(a_in_ready), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 32'(a_in_ready), 32'd1);
    check("rst.req_valid", 32'(a_req_valid), 32'd0);
    check("rst.out_valid", 32'(a_out_valid), 32'd0);
    check("rst.rdata", a_rdata, 32'd0);
    check("rst.err", 32'(a_err), 32'd0);

    // tag addr wdata rd wr ro wm mrd merr rdy hold | req maddr we strb wdata rdata err lat
    run_op("lb", 32'h80000003, 0, 1, 0, RD_BYTE, 0, 32'h80112233, 0, 0, 0,
           1, 32'h80000000, 0, 4'h0, 32'h0, 32'hFFFFFF80, 0, 3);
    run_op("lhu", 32'h80000002, 0, 1, 0, RD_HALFU, 0, 32'h8001ABCD, 0, 0, 0,
           1, 32'h80000000, 0, 4'h0, 32'h0, 32'h00008001, 0, 3);
    run_op("lh", 32'h80000002, 0, 1, 0, RD_HALF, 0, 32'h8001ABCD, 0, 0, 0,
           1, 32'h80000000, 0, 4'h0, 32'h0, 32'hFFFF8001, 0, 3);
    run_op("sb", 32'h80000001, 32'h000000A5, 0, 1, 0, WR_BYTE, 32'h0, 0, 5, 0,
           1, 32'h80000000, 1, 4'b0010, 32'h0000A500, 32'h0, 0, 8);
    run_op("lw_mis", 32'h80000006, 0, 1, 0, RD_WORD, 0, 32'h0, 0, 0, 0,
           0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 1);
    run_op("sh_mis", 32'h80000001, 32'h1234, 0, 1, 0, WR_HALF, 32'h0, 0, 0, 0,
           0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 1);
    run_op("sw_buserr", 32'h80000004, 32'h12345678, 0, 1, 0, WR_WORD, 32'h0, 1, 0, 0,
           1, 32'h80000004, 1, 4'hF, 32'h12345678, 32'h0, 1, 3);
    run_op("sh_hi", 32'h80000002, 32'h0000BEEF, 0, 1, 0, WR_HALF, 32'h0, 0, 0, 0,
           1, 32'h80000000, 1, 4'b1100, 32'hBEEF0000, 32'h0, 0, 3);
    run_op("lbu", 32'h80000001, 0, 1, 0, RD_BYTEU, 0, 32'h0000FE00, 0, 0, 0,
           1, 32'h80000000, 0, 4'h0, 32'h0, 32'h000000FE, 0, 3);
    run_op("nop", 32'h80000003, 0, 0, 0, RD_WORD, 0, 32'h0, 0, 0, 0,
           0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
    run_op("lw_ro0", 32'h80000008, 0, 1, 0, 3'd0, 0, 32'hCAFEF00D, 0, 0, 3,
           1, 32'h80000008, 0, 4'h0, 32'h0, 32'hCAFEF00D, 0, 3);
    run_op("st_wins", 32'h8000000C, 32'h11223344, 1, 1, RD_BYTE, 2'd0, 32'hFFFFFFFF, 0, 0, 0,
           1, 32'h8000000C, 1, 4'hF, 32'h11223344, 32'h0, 0, 3);
    run_op("lb_buserr", 32'h80000000, 0, 1, 0, RD_BYTE, 0, 32'h0000007F, 1, 0, 0,
           1, 32'h80000000, 0, 4'h0, 32'h0, 32'h0000007F, 1, 3);

    // Reset while waiting for a response, then a late response pulse
    @(negedge clk);
    addr = 32'h80000020; MemRead = 1'b1; Ropcode = RD_WORD; in_valid = 1'b1; mem_req_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rstn = 1'b0;
    #1;
    check("arst.in_ready", 32'(a_in_ready), 32'd0);
    check("arst.req_valid", 32'(a_req_valid), 32'd0);
    check("arst.mem_addr", a_maddr, 32'd0);
    check("arst.mem_wdata", a_mwdata, 32'd0);
    check("arst.mem_wstrb", 32'(a_wstrb), 32'd0);
    check("arst.mem_we", 32'(a_we), 32'd0);
    check("arst.out_valid", 32'(a_out_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("arst.late_out_valid", 32'(a_out_valid), 32'd0);
    check("arst.late_in_ready", 32'(a_in_ready), 32'd1);
    check("arst.late_rdata", a_rdata, 32'd0);
    check("arst.late_err", 32'(a_err), 32'd0);
    @(negedge clk);
    check("arst.late_out_valid2", 32'(a_out_valid), 32'd0);

    // Watchdog on the 4-cycle instance
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    use_b = 1'b1;
    @(negedge clk);
    addr = 32'h80000010; MemRead = 1'b1; Ropcode = RD_WORD; in_valid = 1'b1; mem_req_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; MemRead = 1'b0;
    k = 1;
    while (!s_out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    mem_req_ready = 1'b0;
    check("tmo.out_valid", 32'(s_out_valid), 32'd1);
    check("tmo.latency", 32'(k), 32'd5);
    check("tmo.err", 32'(s_err), 32'd1);
    check("tmo.rdata", s_rdata, 32'd0);
    check("tmo.req_valid", 32'(s_req_valid), 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    check("tmo.stray_out_valid", 32'(s_out_valid), 32'd0);
    check("tmo.stray_in_ready", 32'(s_in_ready), 32'd1);
    run_op("tmo_next_lw", 32'h80000014, 0, 1, 0, RD_WORD, 0, 32'h13579BDF, 0, 0, 0,
           1, 32'h80000014, 0, 4'h0, 32'h0, 32'h13579BDF, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
